// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares one single-port scratch DRAM (DEPTH implemented words, 1-cycle
//   registered read) between NREQ requesters. Each cycle a round-robin
//   arbiter accepts at most one command. Accepted commands pass through an
//   issue stage (S1), which drives the DRAM pins, and then a response
//   stage (S2), which returns the response two cycles after acceptance.
//   Out-of-range addresses never reach the DRAM. They come back as error
//   responses.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester command handshake
//   req_we                per-requester write enable (1=write, 0=read)
//   req_addr, req_wdata   packed per-requester address / write data
//   rsp_valid             one-hot response strobe (zero when idle)
//   rsp_err, rsp_rdata    error flag and read data of the current response
//   mem_ena/rea/wea       DRAM strobes
//   mem_addr, mem_dia     DRAM address and write data
//   mem_doa               DRAM registered read data
module dram_port_arbiter #(
  parameter int NREQ  = 2,
  parameter int AW    = 11,
  parameter int DW    = 64,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic               rsp_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_ena,
  output logic               mem_rea,
  output logic               mem_wea,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_dia,
  input  logic [DW-1:0]      mem_doa
);

  localparam int IDW = $clog2(NREQ);
  // One extra bit lets DEPTH == 2**AW be represented in the range compare.
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_idx;
  logic           win_any;

  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_in_range;

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic           s1_we;
  logic           s1_err;

  logic           s2_valid;
  logic [IDW-1:0] s2_id;
  logic           s2_we;
  logic           s2_err;

  // Round-robin search that starts just after the last winner.
  always_comb begin
    int cand;
    cand      = 0;
    win_any   = 1'b0;
    win_idx   = '0;
    req_ready = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!win_any && req_valid[cand]) begin
        win_any = 1'b1;
        win_idx = IDW'(cand);
      end
    end
    if (win_any) req_ready[win_idx] = 1'b1;
  end

  assign sel_we       = req_we[win_idx];
  assign sel_addr     = req_addr[int'(win_idx)*AW +: AW];
  assign sel_wdata    = req_wdata[int'(win_idx)*DW +: DW];
  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_EXT);

  // The pointer only moves on an acceptance, so an idle cycle keeps fairness state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= IDW'(NREQ-1);
    end else if (win_any) begin
      rr_ptr <= win_idx;
    end
  end

  // Issue stage. mem_addr/mem_dia hold on idle cycles. Out-of-range commands
  // zero them so that no stray address reaches the DRAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ena  <= 1'b0;
      mem_rea  <= 1'b0;
      mem_wea  <= 1'b0;
      mem_addr <= '0;
      mem_dia  <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= win_any;
      s1_id    <= win_idx;
      s1_we    <= sel_we;
      s1_err   <= win_any & ~sel_in_range;
      if (win_any && sel_in_range) begin
        mem_ena  <= 1'b1;
        mem_wea  <= sel_we;
        mem_rea  <= ~sel_we;
        mem_addr <= sel_addr;
        mem_dia  <= sel_wdata;
      end else if (win_any) begin
        mem_ena  <= 1'b0;
        mem_wea  <= 1'b0;
        mem_rea  <= 1'b0;
        mem_addr <= '0;
        mem_dia  <= '0;
      end else begin
        mem_ena  <= 1'b0;
        mem_wea  <= 1'b0;
        mem_rea  <= 1'b0;
      end
    end
  end

  // Response stage. It lines up with the cycle in which mem_doa holds the read result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_we    <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_we    <= s1_we;
      s2_err   <= s1_err;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2_valid) rsp_valid[s2_id] = 1'b1;
  end

  assign rsp_err   = s2_valid & s2_err;
  assign rsp_rdata = (s2_valid && !s2_we && !s2_err) ? mem_doa : '0;

endmodule
